// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: registered lookup one cycle after request,
// in-place / invalid-first / round-robin update, and a one-set-per-cycle flush engine.
module btb_assoc #(
    parameter int WIDTH    = 32,
    parameter int SET_BITS = 4,
    parameter int WAYS     = 2,
    parameter int TAG_LEN  = WIDTH - SET_BITS - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lookup_valid,
    input  logic [WIDTH-1:0] lookup_pc,
    output logic             lookup_hit,
    output logic [WIDTH-1:0] lookup_target,
    input  logic             update,
    input  logic [WIDTH-1:0] update_pc,
    input  logic [WIDTH-1:0] update_target,
    input  logic             flush,
    output logic             flush_busy
);
    localparam int NUM_SETS = 1 << SET_BITS;
    localparam int WW       = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t                          state;
    logic [SET_BITS-1:0]             cnt;
    logic [NUM_SETS-1:0][WAYS-1:0]   valid;
    logic [NUM_SETS-1:0][WW-1:0]     victim;
    logic [TAG_LEN-1:0]              tags    [NUM_SETS][WAYS];
    logic [WIDTH-1:0]                targets [NUM_SETS][WAYS];

    logic [SET_BITS-1:0] l_idx, u_idx;
    logic [TAG_LEN-1:0]  l_tag, u_tag;
    logic                l_hit;
    logic [WIDTH-1:0]    l_tgt;
    logic                u_match, u_free, u_fire;
    logic [WW-1:0]       u_match_way, u_free_way, u_way;
    logic                unused_pc_bits;

    assign l_idx = lookup_pc[SET_BITS+1:2];
    assign l_tag = lookup_pc[WIDTH-1:SET_BITS+2];
    assign u_idx = update_pc[SET_BITS+1:2];
    assign u_tag = update_pc[WIDTH-1:SET_BITS+2];
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    assign flush_busy = (state == FLUSH);
    assign u_fire     = (state == IDLE) && update && !flush;

    always_comb begin
        l_hit = 1'b0;
        l_tgt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[l_idx][w] && tags[l_idx][w] == l_tag) begin
                l_hit = 1'b1;
                l_tgt = targets[l_idx][w];
            end
        end
    end

    // Scan downward so the lowest-index free way is the one left selected.
    always_comb begin
        u_match     = 1'b0;
        u_match_way = '0;
        u_free      = 1'b0;
        u_free_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[u_idx][w] && tags[u_idx][w] == u_tag) begin
                u_match     = 1'b1;
                u_match_way = WW'(w);
            end
            if (!valid[u_idx][w]) begin
                u_free     = 1'b1;
                u_free_way = WW'(w);
            end
        end
        u_way = u_match ? u_match_way : (u_free ? u_free_way : victim[u_idx]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            valid         <= '0;
            victim        <= '0;
            lookup_hit    <= 1'b0;
            lookup_target <= '0;
        end else begin
            lookup_hit    <= lookup_valid && (state == IDLE) && l_hit;
            lookup_target <= (lookup_valid && (state == IDLE) && l_hit) ? l_tgt : '0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        state <= FLUSH;
                        cnt   <= '0;
                    end else if (update) begin
                        valid[u_idx][u_way] <= 1'b1;
                        if (!u_match && !u_free && WAYS > 1)
                            victim[u_idx] <= victim[u_idx] + WW'(1);
                    end
                end
                FLUSH: begin
                    valid[cnt]  <= '0;
                    victim[cnt] <= '0;
                    cnt         <= cnt + SET_BITS'(1);
                    if (cnt == SET_BITS'(NUM_SETS - 1))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag and target storage carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if (u_fire) begin
            tags[u_idx][u_way]    <= u_tag;
            targets[u_idx][u_way] <= update_target;
        end
    end
endmodule

// File: doc/btb_assoc.md
# btb_assoc

Parametrised set-associative branch target buffer; next generation of the team's direct-mapped BTB. It sits beside the fetch-stage PC and returns a registered hit/target prediction one cycle after each lookup. Update requests from the execute stage write entries: an existing tag is overwritten in place, otherwise an invalid way is filled first and round-robin replacement is used when the set is full. A multi-cycle flush engine clears all entries on request, for example after fence.i or a context switch.

## Interface
Parameters:
- WIDTH, 32, PC and target width in bits
- SET_BITS, 4, log2 of set count; NUM_SETS = 2**SET_BITS
- WAYS, 2, associativity; power of two, 1..8
- TAG_LEN, WIDTH-SET_BITS-2, derived; not overridden

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- lookup_valid  in  1  lookup request this cycle
- lookup_pc  in  WIDTH  PC to predict
- lookup_hit  out  1  registered hit for the previous cycle's lookup
- lookup_target  out  WIDTH  registered target; 0 when lookup_hit=0
- update  in  1  write request
- update_pc  in  WIDTH  branch PC being written
- update_target  in  WIDTH  resolved target
- flush  in  1  single-cycle flush request
- flush_busy  out  1  flush engine active

## Operation
- Address split: index = pc[SET_BITS+1:2]; tag = pc[WIDTH-1:SET_BITS+2]; pc[1:0] ignored.
- Storage per set and way: valid bit, TAG_LEN tag, WIDTH target. Each set also holds one victim pointer of log2(WAYS) bits (0 bits when WAYS=1).
- Lookup: a way hits when it is valid and its tag matches. At most one way can hit, because updates never create duplicate tags. The hit way's target is registered.
- Update, tag present in set: overwrite that way's target. Victim pointer unchanged.
- Update, tag absent, an invalid way exists: write to the lowest-index invalid way and set it valid. Victim pointer unchanged.
- Update, tag absent, set full: write to way victim[set], then victim[set] <= victim[set]+1 modulo WAYS.
- Flush FSM states:
  - IDLE --flush--> FLUSH with cnt=0.
  - FLUSH: each cycle, clear all valid bits and the victim pointer of set cnt, then increment cnt. After set NUM_SETS-1 is cleared, return to IDLE.
- flush_busy = (state==FLUSH).
- While in FLUSH: updates are dropped, lookups return a miss, and flush is ignored.
- flush and update in the same IDLE cycle: flush wins and the update is dropped.
- Tags and targets are not reset. Only valid bits, victim pointers, FSM state, cnt and the output registers are reset.

## Timing
- Reset (rst=0), asynchronous: all valid bits=0, victim pointers=0, state=IDLE, cnt=0, lookup_hit=0, lookup_target=0, flush_busy=0.
- Lookup latency is 1 cycle. The lookup presented at edge N is reflected in lookup_hit/lookup_target after edge N+1. lookup_valid=0 yields lookup_hit=0 and lookup_target=0 on the next cycle.
- Update is committed at the clock edge. A same-cycle lookup of the same set sees the pre-update contents (no bypass). A lookup in the following cycle sees the new entry.
- Flush takes exactly NUM_SETS cycles with flush_busy high. The first lookup that can hit is presented on the cycle flush_busy drops.
- Reset asserted mid-flush returns the block to IDLE with everything cleared. No resume.
- Back-to-back updates to the same set on consecutive cycles each see the previous update's state, including the victim pointer.

## Test plan
Defaults: WIDTH=32, SET_BITS=4, WAYS=2. PCs 0x1000, 0x2000 and 0x3000 all map to set 0 with distinct tags.
- After reset, lookup 0x1000 -> next cycle lookup_hit=0, lookup_target=0.
- Update 0x1000->0x4000, next cycle lookup 0x1000 -> hit=1, target=0x4000. Same-cycle update+lookup of 0x1000 on an empty BTB -> hit=0.
- Fill set 0 with 0x1000->0xA0 (way0) and 0x2000->0xB0 (way1), then update 0x3000->0xC0 -> 0x1000 misses, 0x2000 hits 0xB0, 0x3000 hits 0xC0. A further update 0x1000->0xD0 evicts 0x2000 (victim=1).
- Update 0x2000->0xE0 while 0x2000 is resident -> same way overwritten, 0x2000 hits 0xE0, the other way's entry is unaffected, victim pointer unchanged.
- Populate several sets, pulse flush -> flush_busy high for exactly 16 cycles. Lookups and updates issued during flush give hit=0 and leave no entry. After flush all lookups miss.
- Pulse flush, deassert rst on cycle 5 of the flush, then release it -> flush_busy=0 immediately, all entries miss, and normal updates work on the next cycle.
